// File: rtl/alu_rs.sv
// Integer reservation station for the single-cycle ALU: collapsing age-ordered queue
// with CDB wakeup, oldest-ready select and a registered issue port.
module alu_rs #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        disp_valid,
   output logic        disp_ready,
   input  logic [2:0]  disp_alu_ext,
   input  logic [2:0]  disp_funct3,
   input  logic [5:0]  disp_rob_tag,
   input  logic        disp_rs1_rdy,
   input  logic        disp_rs2_rdy,
   input  logic [31:0] disp_rs1_data,
   input  logic [31:0] disp_rs2_data,
   input  logic [5:0]  disp_rs1_tag,
   input  logic [5:0]  disp_rs2_tag,
   input  logic        cdb_valid,
   input  logic [5:0]  cdb_tag,
   input  logic [31:0] cdb_data,
   input  logic        iss_ready,
   output logic [31:0] iss_op1,
   output logic [31:0] iss_op2,
   output logic [2:0]  iss_alu_ext,
   output logic [2:0]  iss_funct3,
   output logic [5:0]  iss_tag,
   output logic        iss_tag_valid
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(DEPTH);

   typedef struct packed {
      logic        vld;
      logic [2:0]  ext;
      logic [2:0]  f3;
      logic [5:0]  tag;
      logic        r1;
      logic [5:0]  t1;
      logic [31:0] d1;
      logic        r2;
      logic [5:0]  t2;
      logic [31:0] d2;
   } ent_t;

   ent_t [DEPTH-1:0] r_ent;
   logic [CW-1:0]    r_count;
   logic [31:0]      r_iss_op1, r_iss_op2;
   logic [2:0]       r_iss_ext, r_iss_f3;
   logic [5:0]       r_iss_tag;
   logic             r_iss_vld;

   ent_t [DEPTH:0]   w_upd;
   ent_t [DEPTH-1:0] w_nxt;
   ent_t             w_new;
   logic             w_found, w_adv, w_rem, w_disp;
   logic [SW-1:0]    w_sel;
   logic [CW-1:0]    w_widx;

   assign disp_ready = (r_count < CW'(DEPTH));
   assign w_adv      = !r_iss_vld | iss_ready;
   assign w_rem      = w_adv & w_found;
   assign w_disp     = disp_valid & disp_ready & !flush;
   assign w_widx     = r_count - CW'(w_rem);

   // CDB snoop on every held entry; the extra top slot is an empty filler for the shift
   always_comb begin
      w_upd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_upd[i] = r_ent[i];
         if (cdb_valid && r_ent[i].vld && !r_ent[i].r1 && r_ent[i].t1 == cdb_tag) begin
            w_upd[i].r1 = 1'b1;
            w_upd[i].d1 = cdb_data;
         end
         if (cdb_valid && r_ent[i].vld && !r_ent[i].r2 && r_ent[i].t2 == cdb_tag) begin
            w_upd[i].r2 = 1'b1;
            w_upd[i].d2 = cdb_data;
         end
      end
   end

   // Oldest-ready select from registered ready bits only
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (r_ent[i].vld && r_ent[i].r1 && r_ent[i].r2) begin
            w_found = 1'b1;
            w_sel   = SW'(i);
         end
      end
   end

   always_comb begin
      w_new     = '0;
      w_new.vld = 1'b1;
      w_new.ext = disp_alu_ext;
      w_new.f3  = disp_funct3;
      w_new.tag = disp_rob_tag;
      w_new.r1  = disp_rs1_rdy;
      w_new.t1  = disp_rs1_tag;
      w_new.d1  = disp_rs1_data;
      w_new.r2  = disp_rs2_rdy;
      w_new.t2  = disp_rs2_tag;
      w_new.d2  = disp_rs2_data;
      if (!disp_rs1_rdy && cdb_valid && cdb_tag == disp_rs1_tag) begin
         w_new.r1 = 1'b1;
         w_new.d1 = cdb_data;
      end
      if (!disp_rs2_rdy && cdb_valid && cdb_tag == disp_rs2_tag) begin
         w_new.r2 = 1'b1;
         w_new.d2 = cdb_data;
      end
   end

   // Collapse above the removed slot, then drop the new op into the first free slot
   always_comb begin
      w_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_rem && i >= int'(w_sel)) w_nxt[i] = w_upd[i+1];
         else                           w_nxt[i] = w_upd[i];
         if (w_disp && CW'(i) == w_widx) w_nxt[i] = w_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ent     <= '0;
         r_count   <= '0;
         r_iss_op1 <= '0;
         r_iss_op2 <= '0;
         r_iss_ext <= '0;
         r_iss_f3  <= '0;
         r_iss_tag <= '0;
         r_iss_vld <= 1'b0;
      end else if (flush) begin
         r_ent     <= '0;
         r_count   <= '0;
         r_iss_vld <= 1'b0;
      end else begin
         r_ent     <= w_nxt;
         r_count   <= r_count + CW'(w_disp) - CW'(w_rem);
         if (w_adv) begin
            r_iss_vld <= w_found;
            if (w_found) begin
               r_iss_op1 <= r_ent[w_sel].d1;
               r_iss_op2 <= r_ent[w_sel].d2;
               r_iss_ext <= r_ent[w_sel].ext;
               r_iss_f3  <= r_ent[w_sel].f3;
               r_iss_tag <= r_ent[w_sel].tag;
            end
         end
      end
   end

   assign iss_op1       = r_iss_op1;
   assign iss_op2       = r_iss_op2;
   assign iss_alu_ext   = r_iss_ext;
   assign iss_funct3    = r_iss_f3;
   assign iss_tag       = r_iss_tag;
   assign iss_tag_valid = r_iss_vld;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios with hand-derived expectations, then a
// randomized run against a queue-based reference model.
module tb_alu_rs;
   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        disp_valid = 1'b0, disp_ready;
   logic [2:0]  disp_alu_ext = '0, disp_funct3 = '0;
   logic [5:0]  disp_rob_tag = '0;
   logic        disp_rs1_rdy = 1'b0, disp_rs2_rdy = 1'b0;
   logic [31:0] disp_rs1_data = '0, disp_rs2_data = '0;
   logic [5:0]  disp_rs1_tag = '0, disp_rs2_tag = '0;
   logic        cdb_valid = 1'b0;
   logic [5:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        iss_ready = 1'b1;
   logic [31:0] iss_op1, iss_op2;
   logic [2:0]  iss_alu_ext, iss_funct3;
   logic [5:0]  iss_tag;
   logic        iss_tag_valid;

   int checks = 0, errors = 0;

   alu_rs #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_alu_ext(disp_alu_ext), .disp_funct3(disp_funct3), .disp_rob_tag(disp_rob_tag),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
      .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_ready(iss_ready), .iss_op1(iss_op1), .iss_op2(iss_op2),
      .iss_alu_ext(iss_alu_ext), .iss_funct3(iss_funct3),
      .iss_tag(iss_tag), .iss_tag_valid(iss_tag_valid)
   );

   always #5 clk = ~clk;

   // Reference model state: age-ordered queue plus issue register
   typedef struct {
      logic [2:0]  ext, f3;
      logic [5:0]  tag, t1, t2;
      logic        r1, r2;
      logic [31:0] d1, d2;
   } ment_t;
   ment_t       m_q[$];
   logic        m_iv;
   logic [31:0] m_op1, m_op2;
   logic [2:0]  m_ext, m_f3;
   logic [5:0]  m_tag;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [5:0] tag, input logic r1, input logic [31:0] d1,
                       input logic [5:0] t1, input logic r2, input logic [31:0] d2,
                       input logic [5:0] t2);
      disp_valid = 1'b1; disp_alu_ext = 3'd0; disp_funct3 = 3'd0; disp_rob_tag = tag;
      disp_rs1_rdy = r1; disp_rs1_data = d1; disp_rs1_tag = t1;
      disp_rs2_rdy = r2; disp_rs2_data = d2; disp_rs2_tag = t2;
   endtask

   task automatic clear_flush();
      disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; iss_ready = 1'b1;
   endtask

   task automatic model_step();
      bit acc;
      int sel;
      ment_t e;
      if (flush) begin
         m_q.delete();
         m_iv = 1'b0;
         return;
      end
      acc = disp_valid && (m_q.size() < DEPTH);
      sel = -1;
      foreach (m_q[i]) if (sel < 0 && m_q[i].r1 && m_q[i].r2) sel = i;
      foreach (m_q[i]) begin
         if (cdb_valid && !m_q[i].r1 && m_q[i].t1 == cdb_tag) begin m_q[i].r1 = 1'b1; m_q[i].d1 = cdb_data; end
         if (cdb_valid && !m_q[i].r2 && m_q[i].t2 == cdb_tag) begin m_q[i].r2 = 1'b1; m_q[i].d2 = cdb_data; end
      end
      if (!m_iv || iss_ready) begin
         if (sel >= 0) begin
            m_iv = 1'b1; m_op1 = m_q[sel].d1; m_op2 = m_q[sel].d2;
            m_ext = m_q[sel].ext; m_f3 = m_q[sel].f3; m_tag = m_q[sel].tag;
            m_q.delete(sel);
         end else m_iv = 1'b0;
      end
      if (acc) begin
         e.ext = disp_alu_ext; e.f3 = disp_funct3; e.tag = disp_rob_tag;
         e.t1 = disp_rs1_tag; e.t2 = disp_rs2_tag;
         e.r1 = disp_rs1_rdy || (cdb_valid && cdb_tag == disp_rs1_tag);
         e.r2 = disp_rs2_rdy || (cdb_valid && cdb_tag == disp_rs2_tag);
         e.d1 = disp_rs1_rdy ? disp_rs1_data : cdb_data;
         e.d2 = disp_rs2_rdy ? disp_rs2_data : cdb_data;
         m_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      checks++;
      if ({iss_tag_valid, disp_ready, iss_tag, iss_op1, iss_op2, iss_alu_ext, iss_funct3} !==
          {1'b0, 1'b1, 6'd0, 32'd0, 32'd0, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL reset vld=%0b rdy=%0b tag=%0d op1=%h op2=%h exp vld=0 rdy=1 all zero",
                  iss_tag_valid, disp_ready, iss_tag, iss_op1, iss_op2);
      end
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      disp(6'd5, 1'b1, 32'h10, 6'd0, 1'b1, 32'h20, 6'd0);
      iss_ready = 1'b1;
      tick();
      disp_valid = 1'b0;
      checks++;
      if (iss_tag_valid !== 1'b0) begin errors++; $display("FAIL basic_early vld=%0b exp 0", iss_tag_valid); end
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 6'd5, 32'h10, 32'h20}) begin
         errors++;
         $display("FAIL basic_issue vld=%0b tag=%0d op1=%h op2=%h exp 1/5/10/20", iss_tag_valid, iss_tag, iss_op1, iss_op2);
      end
      tick();
      checks++;
      if (iss_tag_valid !== 1'b0) begin errors++; $display("FAIL basic_oneshot vld=%0b exp 0", iss_tag_valid); end
   endtask

   task automatic test_wakeup();
      disp(6'd7, 1'b0, 32'h0, 6'd3, 1'b1, 32'h2, 6'd0);
      tick();
      disp(6'd8, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0);
      tick();
      disp_valid = 1'b0;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag} !== {1'b1, 6'd8}) begin
         errors++; $display("FAIL wake_young_first vld=%0b tag=%0d exp 1/8", iss_tag_valid, iss_tag);
      end
      cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'hABCD;
      tick();
      cdb_valid = 1'b0;
      checks++;
      if (iss_tag_valid !== 1'b0) begin errors++; $display("FAIL wake_no_forward vld=%0b exp 0", iss_tag_valid); end
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 6'd7, 32'hABCD, 32'h2}) begin
         errors++;
         $display("FAIL wake_issue vld=%0b tag=%0d op1=%h op2=%h exp 1/7/abcd/2", iss_tag_valid, iss_tag, iss_op1, iss_op2);
      end
      tick();
   endtask

   task automatic test_bypass();
      disp(6'd10, 1'b1, 32'h1, 6'd0, 1'b0, 32'h0, 6'd9);
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h55;
      tick();
      disp_valid = 1'b0; cdb_valid = 1'b0;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op2} !== {1'b1, 6'd10, 32'h55}) begin
         errors++; $display("FAIL bypass vld=%0b tag=%0d op2=%h exp 1/10/55", iss_tag_valid, iss_tag, iss_op2);
      end
      tick();
   endtask

   task automatic test_full();
      iss_ready = 1'b0;
      disp(6'd19, 1'b1, 32'h19, 6'd0, 1'b1, 32'h0, 6'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         disp(6'(20 + k), 1'b0, 32'h0, 6'(40 + k), 1'b1, 32'h0, 6'd0);
         tick();
      end
      checks++;
      if ({disp_ready, iss_tag_valid, iss_tag} !== {1'b0, 1'b1, 6'd19}) begin
         errors++; $display("FAIL full_ready rdy=%0b vld=%0b tag=%0d exp 0/1/19", disp_ready, iss_tag_valid, iss_tag);
      end
      disp(6'd24, 1'b1, 32'h24, 6'd0, 1'b1, 32'h0, 6'd0);
      tick();
      disp_valid = 1'b0;
      checks++;
      if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_reject rdy=%0b exp 0", disp_ready); end
      cdb_valid = 1'b1; cdb_tag = 6'd42; cdb_data = 32'h42;
      tick();
      cdb_valid = 1'b0;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, disp_ready} !== {1'b1, 6'd19, 32'h19, 1'b0}) begin
         errors++; $display("FAIL full_hold vld=%0b tag=%0d op1=%h rdy=%0b exp 1/19/19/0", iss_tag_valid, iss_tag, iss_op1, disp_ready);
      end
      iss_ready = 1'b1;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, disp_ready} !== {1'b1, 6'd22, 32'h42, 1'b1}) begin
         errors++; $display("FAIL full_drain vld=%0b tag=%0d op1=%h rdy=%0b exp 1/22/42/1", iss_tag_valid, iss_tag, iss_op1, disp_ready);
      end
      clear_flush();
   endtask

   task automatic test_back_to_back();
      iss_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(6'(30 + k), 1'b1, 32'(30 + k), 6'd0, 1'b1, 32'(130 + k), 6'd0);
         tick();
      end
      disp_valid = 1'b0;
      checks++;
      if ({iss_tag_valid, iss_tag} !== {1'b1, 6'd30}) begin
         errors++; $display("FAIL b2b_first vld=%0b tag=%0d exp 1/30", iss_tag_valid, iss_tag);
      end
      iss_ready = 1'b1;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 6'd31, 32'd31, 32'd131}) begin
         errors++; $display("FAIL b2b_second vld=%0b tag=%0d op1=%h exp 1/31/1f", iss_tag_valid, iss_tag, iss_op1);
      end
      iss_ready = 1'b0;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, iss_op2} !== {1'b1, 6'd31, 32'd31, 32'd131}) begin
         errors++; $display("FAIL b2b_stall vld=%0b tag=%0d op1=%h exp 1/31/1f", iss_tag_valid, iss_tag, iss_op1);
      end
      iss_ready = 1'b1;
      tick();
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1} !== {1'b1, 6'd32, 32'd32}) begin
         errors++; $display("FAIL b2b_third vld=%0b tag=%0d op1=%h exp 1/32/20", iss_tag_valid, iss_tag, iss_op1);
      end
      tick();
      checks++;
      if (iss_tag_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty vld=%0b exp 0", iss_tag_valid); end
   endtask

   task automatic test_flush();
      iss_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         disp(6'(50 + k), 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0);
         tick();
      end
      disp(6'd53, 1'b1, 32'h3, 6'd0, 1'b1, 32'h4, 6'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b1;
      checks++;
      if ({iss_tag_valid, disp_ready} !== {1'b0, 1'b1}) begin
         errors++; $display("FAIL flush_clear vld=%0b rdy=%0b exp 0/1", iss_tag_valid, disp_ready);
      end
      tick(); tick();
      checks++;
      if (iss_tag_valid !== 1'b0) begin
         errors++; $display("FAIL flush_absent vld=%0b tag=%0d exp vld 0", iss_tag_valid, iss_tag);
      end
      disp(6'd60, 1'b1, 32'h60, 6'd0, 1'b1, 32'h61, 6'd0);
      tick();
      disp_valid = 1'b0;
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({iss_tag_valid, iss_tag, iss_op1, iss_op2, disp_ready} !== {1'b0, 6'd0, 32'd0, 32'd0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset vld=%0b tag=%0d op1=%h op2=%h rdy=%0b exp 0/0/0/0/1",
                  iss_tag_valid, iss_tag, iss_op1, iss_op2, disp_ready);
      end
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic exp_rdy;
      disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      m_q.delete();
      m_iv = 1'b0; m_op1 = '0; m_op2 = '0; m_ext = '0; m_f3 = '0; m_tag = '0;
      for (int c = 0; c < 3000; c++) begin
         disp_valid    = ($urandom_range(0, 9) < 6);
         disp_alu_ext  = 3'($urandom_range(0, 5));
         disp_funct3   = 3'($urandom);
         disp_rob_tag  = 6'($urandom);
         disp_rs1_rdy  = ($urandom_range(0, 4) < 2);
         disp_rs2_rdy  = ($urandom_range(0, 4) < 2);
         disp_rs1_data = $urandom;
         disp_rs2_data = $urandom;
         disp_rs1_tag  = 6'($urandom_range(0, 7));
         disp_rs2_tag  = 6'($urandom_range(0, 7));
         cdb_valid     = ($urandom_range(0, 1) == 1);
         cdb_tag       = 6'($urandom_range(0, 7));
         cdb_data      = $urandom;
         iss_ready     = ($urandom_range(0, 9) < 7);
         flush         = ($urandom_range(0, 99) == 0);
         exp_rdy = (m_q.size() < DEPTH);
         checks++;
         if (disp_ready !== exp_rdy) begin
            errors++; $display("FAIL rnd_disp_ready cyc=%0d got %0b exp %0b", c, disp_ready, exp_rdy);
         end
         model_step();
         tick();
         checks++;
         if ({iss_tag_valid, iss_tag, iss_alu_ext, iss_funct3, iss_op1, iss_op2} !==
             {m_iv, m_tag, m_ext, m_f3, m_op1, m_op2}) begin
            errors++;
            $display("FAIL rnd_issue cyc=%0d got vld=%0b tag=%0d ext=%0d f3=%0d op1=%h op2=%h exp vld=%0b tag=%0d ext=%0d f3=%0d op1=%h op2=%h",
                     c, iss_tag_valid, iss_tag, iss_alu_ext, iss_funct3, iss_op1, iss_op2,
                     m_iv, m_tag, m_ext, m_f3, m_op1, m_op2);
         end
      end
      disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_full();
      test_back_to_back();
      test_flush();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_rs.md
# alu_rs

Integer reservation station that feeds the single-cycle ALU execution unit in the Tomasulo back end. Accepts dispatched ALU/branch/jump micro-ops from the dispatch stage, holds them until both source operands are available by snooping the common data bus (CDB), and issues the oldest ready entry per cycle through a registered issue port that drives the ALU unit's op1/op2/alu_ext/funct3/tag_in/tag_in_valid inputs. Supports pipeline flush on branch mispredict.

## Interface
- DEPTH, 4, number of station entries (2..8)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all entries and the issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch this cycle
- disp_alu_ext  in  3  ALU extension code (0 R/I-type, 1 JAL, 2 JALR, 3 branch, 4 SUB/SRA form, 5 LUI/AUIPC), stored verbatim
- disp_funct3  in  3  funct3 field, stored verbatim
- disp_rob_tag  in  6  destination ROB tag
- disp_rs1_rdy / disp_rs2_rdy  in  1  operand data already valid
- disp_rs1_data / disp_rs2_data  in  32  operand data (used when rdy=1)
- disp_rs1_tag / disp_rs2_tag  in  6  producer tag (used when rdy=0)
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  6  CDB broadcast tag
- cdb_data  in  32  CDB broadcast data
- iss_ready  in  1  ALU result slot granted downstream; issue register may advance
- iss_op1 / iss_op2  out  32  operands to ALU
- iss_alu_ext  out  3  to ALU
- iss_funct3  out  3  to ALU
- iss_tag  out  6  ROB tag to ALU tag_in
- iss_tag_valid  out  1  issue register holds a valid op

## Operation
- Storage: collapsing queue, entry 0 oldest; each entry holds valid, alu_ext, funct3, rob_tag, and per operand {rdy, tag, data}. count = number of valid entries.
- disp_ready = (count < DEPTH), combinational from registered count only (does not credit same-cycle issue). Dispatch accepted when disp_valid & disp_ready & !flush.
- Dispatch CDB bypass: if an operand has rdy=0 and cdb_valid & cdb_tag == operand tag in the dispatch cycle, the entry is written with rdy=1, data=cdb_data.
- Snoop: every valid entry operand with rdy=0 and matching cdb_tag while cdb_valid captures cdb_data and sets rdy=1 at the edge. Both operands may match the same broadcast.
- Select: lowest-index valid entry with both rdy bits set (registered values; no same-cycle CDB-to-issue forwarding).
- Issue register advance when !iss_tag_valid | iss_ready: load selected entry into iss_* with iss_tag_valid=1 and remove it (entries above shift down one); if none selected, iss_tag_valid=0 (other iss_* hold).
- If advance is not allowed, iss_* hold and no entry is removed.
- Simultaneous dispatch and removal: shift first, new entry written at index count-1 (net count unchanged).
- An entry being shifted still applies that cycle's CDB snoop.
- flush: at next edge all entries invalid, count=0, iss_tag_valid=0; concurrent dispatch and CDB capture discarded. flush overrides everything except rst_n.
- Reset (rst_n=0, asynchronous): all entries invalid, count=0, iss_op1/iss_op2=0, iss_alu_ext=0, iss_funct3=0, iss_tag=0, iss_tag_valid=0; disp_ready=1.

## Timing
- Dispatch with both operands ready at edge N into empty station, iss_ready=1: iss_tag_valid=1 after edge N+1 (2-cycle latency).
- Operand woken by CDB at edge N: entry eligible for select in cycle after N, issued at edge N+1.
- Throughput: one issue per cycle when iss_ready held high and ready entries exist.
- Full: after DEPTH accepted dispatches without issue, disp_ready=0 until the edge that removes an entry.
- iss_* stable while iss_tag_valid=1 & iss_ready=0.

## Test plan
- Reset then dispatch {ext=0,funct3=0,tag=5,rs1=0x10 rdy,rs2=0x20 rdy}, iss_ready=1 -> two edges later iss_op1=0x10, iss_op2=0x20, iss_tag=5, iss_tag_valid=1 for one cycle.
- Dispatch tag 7 with rs1 waiting on tag 3, then tag 8 both ready -> tag 8 issues first; CDB {tag 3, 0xABCD} -> tag 7 issues next cycle after capture with iss_op1=0xABCD.
- Dispatch with rs2 tag 9 while cdb_valid tag 9 data 0x55 same cycle -> entry issues as ready, iss_op2=0x55.
- Fill DEPTH=4 entries all waiting, iss_ready=0 -> disp_ready=0, 5th disp_valid not accepted; broadcast wakes entry 2 -> with iss_ready=0 iss holds; raise iss_ready -> disp_ready returns 1 the cycle after removal.
- Three ready entries, iss_ready toggled 1/0/1 -> issued in age order, iss_* stable during iss_ready=0 cycle.
- Two entries held plus valid issue register, assert flush with concurrent dispatch -> next cycle count=0, iss_tag_valid=0, disp_ready=1, dispatched op absent; async rst_n pulse mid-operation -> all outputs to reset values immediately.
